link_transmitter: RTL
=====================

// Module: link_transmitter
// PURPOSE
//  Serialising end of the master/slave link: takes one parallel frame from the game logic and
//  shifts it out on S_OUT, bit 0 first, one bit per LINK_CLK, with SYNC high on the final bit.
//  Frames are captured in full by the slave-side receiver on the SYNC cycle (RECV_OK pulse).
//  A one-entry holding register lets the next frame queue while the current one shifts.
// PARAMETERS
//  FRAME_W     49  frame width in bits; must equal the receiver's frame width (49)
//  GAP_CYCLES  1   idle cycles (S_OUT=0, SYNC=0) inserted after each frame; 0 = back-to-back
//  CNT_W       6   bit-counter width, >= clog2(FRAME_W) and >= clog2(GAP_CYCLES+1)
// PORTS
//  LINK_CLK    in   1          link clock, shared with receiver; all logic on posedge
//  RESET       in   1          synchronous, active-high reset
//  DATA_IN     in   [0:FRAME_W-1]  frame to send; bit 0 transmitted first
//  LOAD        in   1          request to queue DATA_IN; accepted only when READY=1
//  READY       out  1          holding register empty; = ~HOLD_VALID (registered state)
//  BUSY        out  1          1 while state != IDLE
//  S_OUT       out  1          serial data, registered
//  SYNC        out  1          high exactly during the last bit (bit FRAME_W-1) of a frame, registered
// BEHAVIOUR
//  Reset (sync, RESET=1 at posedge): state=IDLE, HOLD_VALID=0, counters=0, S_OUT=0, SYNC=0,
//   BUSY=0, READY=1. Applies mid-frame: frame truncated, queued frame discarded, next cycle
//   S_OUT=0/SYNC=0; SYNC never issued for a truncated frame, so receiver emits nothing.
//  Accept: posedge with LOAD=1 & READY=1 -> HOLD<=DATA_IN, HOLD_VALID<=1. LOAD with READY=0
//   ignored (no overwrite, no error). No same-cycle refill: READY stays 0 on the transfer edge.
//  States IDLE, SHIFT, GAP:
//   IDLE : S_OUT=0, SYNC=0. If HOLD_VALID: SHR<=HOLD, HOLD_VALID<=0, S_OUT<=HOLD[0], CNT<=0 -> SHIFT.
//   SHIFT: S_OUT carries bit CNT; each edge CNT+1, S_OUT<=SHR[CNT+1]. SYNC<=1 on the edge loading
//          bit FRAME_W-1, SYNC<=0 on the following edge. After bit FRAME_W-1:
//          GAP_CYCLES>0 -> GAP (CNT<=0); GAP_CYCLES=0 & HOLD_VALID -> reload, stay SHIFT, bit 0
//          on next cycle (no gap); else -> IDLE.
//   GAP  : S_OUT=0, SYNC=0 for exactly GAP_CYCLES cycles, then IDLE rules apply in the same edge
//          (HOLD_VALID -> SHIFT directly, bit 0 follows the last gap cycle).
//  Latency: LOAD sampled at edge n (idle) -> bit 0 on S_OUT after edge n+1; SYNC after edge n+FRAME_W.
//  Frame period = FRAME_W + GAP_CYCLES cycles when HOLD is always refilled.
//  DATA_IN only sampled on accept edge; later changes do not affect the frame in flight.
//  CNT never exceeds FRAME_W-1 in SHIFT nor GAP_CYCLES-1 in GAP; no wrap.
// STRUCTURE
//  Shared header link_defs.vh: `LINK_FRAME_W (49), frame field offsets used by game logic,
//   state encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2). Receiver and transmitter both include it.
//  Single module; the shift register + bit counter may be split into sub-module link_piso
//   (parallel-in serial-out, load/shift enable, last-bit flag) if reused by the master side.
// TESTING
//  1 Reset: hold RESET 3 cycles -> S_OUT=0, SYNC=0, BUSY=0, READY=1 on every cycle.
//  2 Single frame: LOAD DATA_IN=49'h1_0000_0000_0001 -> S_OUT=1 on bit 0, 0 on bits 1..47,
//    1 on bit 48 with SYNC=1 that cycle only; BUSY drops after GAP_CYCLES idle cycles.
//  3 Back-to-back, GAP_CYCLES=0: queue 49'h0_AAAA_AAAA_AAAA then 49'h1_5555_5555_5555 ->
//    98 contiguous bits, SYNC high on cycles 49 and 98 only, READY=1 again after first transfer.
//  4 LOAD while READY=0 with DATA_IN=49'h1_FFFF_FFFF_FFFF -> ignored; queued frame sent intact.
//  5 RESET at bit 20 of a frame with one queued -> S_OUT=0/SYNC=0 next cycle, no SYNC emitted,
//    queued frame lost, READY=1.
//  6 Loopback to receiver (same LINK_CLK, S_IN=S_OUT, SYNC=SYNC), 200 random frames ->
//    RECV_OK pulses once per frame, DATA_OUT equals each DATA_IN in order.

Source files
------------

// File: rtl/link_transmitter_pkg.sv
// link_transmitter_pkg: shared frame width and transmitter state encoding
package link_transmitter_pkg;
    localparam int LINK_FRAME_W = 49;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} tx_state_t;
endpackage

// File: rtl/link_transmitter_piso.sv
// link_transmitter_piso: parallel-in serial-out shifter, bit 0 first, registered last-bit flag
module link_transmitter_piso
    import link_transmitter_pkg::*;
#(
    parameter int FRAME_W = LINK_FRAME_W,
    parameter int CNT_W   = 6
) (
    input  logic               LINK_CLK,
    input  logic               RESET,
    input  logic               load,
    input  logic               shift,
    input  logic [0:FRAME_W-1] data,
    output logic               bit_out,
    output logic               last
);
    logic [0:FRAME_W-1] shr;
    logic [CNT_W-1:0]   cnt;
    // zero-fill keeps the line low once the final bit has left
    assign bit_out = shr[0];
    always_ff @(posedge LINK_CLK) begin
        if (RESET) begin
            shr  <= '0;
            cnt  <= '0;
            last <= 1'b0;
        end else if (load) begin
            shr  <= data;
            cnt  <= '0;
            last <= 1'b0;
        end else begin
            shr  <= {shr[1:FRAME_W-1], 1'b0};
            cnt  <= shift ? cnt + 1'b1 : '0;
            last <= shift && cnt == CNT_W'(FRAME_W-2);
        end
    end
endmodule

// File: rtl/link_transmitter.sv
// link_transmitter: serialises queued frames onto S_OUT with SYNC on the last bit
module link_transmitter
    import link_transmitter_pkg::*;
#(
    parameter int FRAME_W    = LINK_FRAME_W,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 6
) (
    input  logic               LINK_CLK,
    input  logic               RESET,
    input  logic [0:FRAME_W-1] DATA_IN,
    input  logic               LOAD,
    output logic               READY,
    output logic               BUSY,
    output logic               S_OUT,
    output logic               SYNC
);
    tx_state_t          state, state_nx;
    logic [0:FRAME_W-1] hold;
    logic               hold_valid;
    logic               piso_load, piso_shift, gap_done;
    logic [CNT_W-1:0]   gap_cnt;
    assign READY    = ~hold_valid;
    assign BUSY     = state != IDLE;
    assign gap_done = gap_cnt == CNT_W'(GAP_CYCLES-1);
    link_transmitter_piso #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) u_piso (
        .LINK_CLK(LINK_CLK),
        .RESET   (RESET),
        .load    (piso_load),
        .shift   (piso_shift),
        .data    (hold),
        .bit_out (S_OUT),
        .last    (SYNC)
    );
    // SYNC doubles as "current bit is the last one"
    always_comb begin
        state_nx   = state;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        case (state)
            IDLE: begin
                piso_load = hold_valid;
                state_nx  = hold_valid ? SHIFT : IDLE;
            end
            SHIFT: begin
                piso_shift = !SYNC;
                piso_load  = SYNC && GAP_CYCLES == 0 && hold_valid;
                if (SYNC)
                    state_nx = GAP_CYCLES > 0 ? GAP : (hold_valid ? SHIFT : IDLE);
            end
            GAP: begin
                piso_load = gap_done && hold_valid;
                if (gap_done)
                    state_nx = hold_valid ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge LINK_CLK) begin
        if (RESET) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            state   <= state_nx;
            gap_cnt <= state == GAP && !gap_done ? gap_cnt + 1'b1 : '0;
            if (piso_load)
                hold_valid <= 1'b0;
            else if (LOAD && READY) begin
                hold       <= DATA_IN;
                hold_valid <= 1'b1;
            end
        end
    end
endmodule
